// File: rtl/product_shift_pkg.sv
// product_shift_pkg: adaptive FIR filter widths and shared fixed-point rescale helpers
package product_shift_pkg;
  localparam int WEIGHT_W = 32;
  localparam int SAMPLE_W = 14;
  localparam int PROD_W = 46;
  localparam int ACC_W = 32;
  localparam int FRAC_BITS = 14;
  localparam int CALC_W = 64;
  function automatic logic signed [CALC_W-1:0] round_shift(input logic signed [CALC_W-1:0] s, input int frac, input logic rnd);
    logic signed [CALC_W-1:0] half;
    half = (rnd && frac > 0) ? 64'sd1 <<< (frac - 1) : '0;
    return (s + half) >>> frac;
  endfunction
  function automatic logic signed [CALC_W-1:0] sat_signed(input logic signed [CALC_W-1:0] q, input int w);
    logic signed [CALC_W-1:0] hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    return q > hi ? hi : q < lo ? lo : q;
  endfunction
endpackage

// File: rtl/product_shift.sv
// product_shift: registered round/shift/saturate rescaler for one FIR tap product
module product_shift #(
  parameter int IN_W = product_shift_pkg::PROD_W,
  parameter int OUT_W = product_shift_pkg::ACC_W,
  parameter int FRAC_BITS = product_shift_pkg::FRAC_BITS,
  parameter int ROUND = 1,
  parameter int SAT = 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic signed [IN_W-1:0]  in,
  output logic signed [OUT_W-1:0] out
);
  import product_shift_pkg::*;
  logic signed [CALC_W-1:0] q;
  logic signed [OUT_W-1:0] nxt;
  // the wide working width holds the rounding add without overflow
  always_comb begin
    q = round_shift(CALC_W'(in), FRAC_BITS, ROUND != 0);
    nxt = OUT_W'(SAT != 0 ? sat_signed(q, OUT_W) : q);
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) out <= '0;
    else out <= nxt;
endmodule

// File: tb/tb_product_shift.sv
// tb_product_shift: directed and randomized checks of product_shift against an arithmetic model
module tb_product_shift;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic signed [45:0] in = '0;
  logic [31:0] o_main, o_nosat, o_f0, o_r0;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  product_shift u_main (.clk(clk), .rstn(rstn), .in(in), .out(o_main));
  product_shift #(.SAT(0)) u_nosat (.clk(clk), .rstn(rstn), .in(in), .out(o_nosat));
  product_shift #(.FRAC_BITS(0)) u_f0 (.clk(clk), .rstn(rstn), .in(in), .out(o_f0));
  product_shift #(.ROUND(0)) u_r0 (.clk(clk), .rstn(rstn), .in(in), .out(o_r0));
  function automatic logic [31:0] gold(input longint x, input int frac, input bit rnd, input bit sat);
    longint maxv = 64'sh7FFF_FFFF;
    longint minv = -maxv - 1;
    longint d = longint'(1) << frac;
    longint v = x + ((rnd && frac > 0) ? (longint'(1) << (frac - 1)) : 0);
    longint q = v / d;
    if (v % d != 0 && v < 0) q = q - 1;
    if (sat) q = q > maxv ? maxv : (q < minv ? minv : q);
    return q[31:0];
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step(input longint v, input logic [31:0] exp, input string tag);
    in = 46'(v);
    @(posedge clk);
    @(negedge clk);
    chk(tag, o_main, exp);
    chk({tag, "_nosat"}, o_nosat, gold(v, 14, 1, 0));
    chk({tag, "_frac0"}, o_f0, gold(v, 0, 1, 1));
    chk({tag, "_trunc"}, o_r0, gold(v, 14, 0, 1));
  endtask
  initial begin
    longint r;
    in = 46'h4000;
    #1 chk("reset_state", o_main, 32'h0);
    @(negedge clk) rstn = 1'b1;
    @(posedge clk);
    @(negedge clk) chk("first_after_reset", o_main, 32'h1);
    #2 rstn = 1'b0;
    #1 chk("async_reset", o_main, 32'h0);
    @(posedge clk);
    @(negedge clk) chk("reset_hold", o_main, 32'h0);
    rstn = 1'b1;
    @(posedge clk);
    @(negedge clk) chk("reset_release", o_main, 32'h1);
    step(64'sh4000, 32'h1, "s_4000");
    step(64'sh2000, 32'h1, "s_2000");
    step(64'sh1FFF, 32'h0, "s_1fff");
    step(64'sh6000, 32'h2, "s_6000");
    step(0, 32'h0, "s_zero");
    step(-16384, 32'hFFFF_FFFF, "n_16384");
    step(-8193, 32'hFFFF_FFFF, "n_8193");
    step(-8192, 32'h0, "n_tie");
    step((longint'(1) << 45) - 1, 32'h7FFF_FFFF, "sat_pos");
    chk("nosat_wrap", o_nosat, 32'h8000_0000);
    chk("frac0_clamp", o_f0, 32'h7FFF_FFFF);
    step(-(longint'(1) << 45), 32'h8000_0000, "sat_neg");
    step(-1, 32'h0, "m1");
    chk("trunc_floor", o_r0, 32'hFFFF_FFFF);
    step(5, 32'h0, "five");
    chk("frac0_pass", o_f0, 32'h5);
    for (int i = 0; i < 1000; i++) begin
      r = longint'({$urandom(), $urandom()});
      r = r >>> (18 + $urandom_range(0, 40));
      step(r, gold(r, 14, 1, 1), "stream");
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
